// File: rtl/demux_1ne4_24bit_if.sv
// Bus bundle for the registered 1-to-4 demultiplexer: one producer port and
// four consumer lanes, each with its own valid/ready handshake.
interface demux_1ne4_24bit_if #(
    parameter int unsigned WIDTH = 24
);
    logic [WIDTH-1:0] Hyrja;
    logic [1:0]       S;
    logic             HyrjaValid;
    logic             HyrjaReady;
    logic [WIDTH-1:0] Dalja0;
    logic [WIDTH-1:0] Dalja1;
    logic [WIDTH-1:0] Dalja2;
    logic [WIDTH-1:0] Dalja3;
    logic [3:0]       DaljaValid;
    logic [3:0]       DaljaReady;
    logic [2:0]       Zene;

    modport master (
        output Hyrja, S, HyrjaValid, DaljaReady,
        input  HyrjaReady, Dalja0, Dalja1, Dalja2, Dalja3, DaljaValid, Zene
    );

    modport slave (
        input  Hyrja, S, HyrjaValid, DaljaReady,
        output HyrjaReady, Dalja0, Dalja1, Dalja2, Dalja3, DaljaValid, Zene
    );
endinterface

// File: rtl/demux_1ne4_24bit.sv
// Registered 1-to-4 demultiplexer: steers an accepted word into a one-entry
// holding register per lane; each lane drains independently to its consumer.
module demux_1ne4_24bit #(
    parameter int unsigned WIDTH = 24
) (
    input  logic                Clock_i,
    input  logic                Reset_i,
    demux_1ne4_24bit_if.slave   bus
);
    typedef enum logic {
        LANE_EMPTY = 1'b0,
        LANE_FULL  = 1'b1
    } lane_state_e;

    lane_state_e      state_q [4];
    lane_state_e      state_d [4];
    logic [WIDTH-1:0] data_q  [4];
    logic [WIDTH-1:0] data_d  [4];
    logic [2:0]       zene_q;
    logic [2:0]       zene_d;
    logic             hyrja_ready;
    logic             acc;
    logic [3:0]       acc_lane;
    logic [3:0]       drain;
    logic [3:0]       valid_vec;

    // Readiness looks only at the addressed lane, so a stalled lane never blocks others.
    always_comb begin
        hyrja_ready = (state_q[bus.S] == LANE_EMPTY) || bus.DaljaReady[bus.S];
        acc         = bus.HyrjaValid && hyrja_ready;
    end

    always_comb begin
        acc_lane  = '0;
        drain     = '0;
        valid_vec = '0;
        zene_d    = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            state_d[i]   = state_q[i];
            data_d[i]    = data_q[i];
            valid_vec[i] = (state_q[i] == LANE_FULL);
            acc_lane[i]  = acc && (bus.S == 2'(i));
            drain[i]     = valid_vec[i] && bus.DaljaReady[i];
            if (acc_lane[i]) begin
                state_d[i] = LANE_FULL;
                data_d[i]  = bus.Hyrja;
            end else if (drain[i]) begin
                state_d[i] = LANE_EMPTY;
            end
            if (state_d[i] == LANE_FULL) begin
                zene_d = zene_d + 3'd1;
            end
        end
    end

    always_ff @(posedge Clock_i) begin
        if (Reset_i) begin
            for (int unsigned i = 0; i < 4; i++) begin
                state_q[i] <= LANE_EMPTY;
                data_q[i]  <= '0;
            end
            zene_q <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                data_q[i]  <= data_d[i];
            end
            zene_q <= zene_d;
        end
    end

    assign bus.HyrjaReady = hyrja_ready;
    assign bus.DaljaValid = valid_vec;
    assign bus.Dalja0     = data_q[0];
    assign bus.Dalja1     = data_q[1];
    assign bus.Dalja2     = data_q[2];
    assign bus.Dalja3     = data_q[3];
    assign bus.Zene       = zene_q;
endmodule

// File: tb/tb_demux_1ne4_24bit.sv
// Self-checking bench for demux_1ne4_24bit: directed scenarios plus a long
// randomized run against a per-lane occupancy/data reference model.
module tb_demux_1ne4_24bit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    demux_1ne4_24bit_if #(.WIDTH(24)) ifc ();

    demux_1ne4_24bit #(.WIDTH(24)) dut (
        .Clock_i (clk),
        .Reset_i (rst),
        .bus     (ifc.slave)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference model: what each lane currently holds and whether it is owed to its consumer.
    logic        mvalid [4];
    logic [23:0] mdata  [4];
    int unsigned model_acc = 0;
    int unsigned obs_acc   = 0;

    function automatic logic [3:0] mvec();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = mvalid[i];
        return v;
    endfunction

    function automatic logic [2:0] mzene();
        logic [2:0] n = 3'd0;
        for (int i = 0; i < 4; i++) if (mvalid[i]) n = n + 3'd1;
        return n;
    endfunction

    function automatic logic [23:0] lane_out(input int i);
        case (i)
            0:       return ifc.Dalja0;
            1:       return ifc.Dalja1;
            2:       return ifc.Dalja2;
            default: return ifc.Dalja3;
        endcase
    endfunction

    // One clock cycle: drive at negedge, observe ready, advance model at posedge, return at negedge.
    task automatic step(input logic v, input logic [1:0] s, input logic [23:0] d,
                        input logic [3:0] dr, input logic r,
                        output logic rdy_obs, output logic rdy_exp);
        rst             = r;
        ifc.HyrjaValid  = v;
        ifc.S           = s;
        ifc.Hyrja       = d;
        ifc.DaljaReady  = dr;
        #1;
        rdy_obs = ifc.HyrjaReady;
        rdy_exp = !mvalid[s] || dr[s];
        if (!r && v && rdy_obs) obs_acc++;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                mvalid[i] = 1'b0;
                mdata[i]  = 24'h0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (v && rdy_exp && s == 2'(i)) begin
                    mvalid[i] = 1'b1;
                    mdata[i]  = d;
                    model_acc++;
                end else if (mvalid[i] && dr[i]) begin
                    mvalid[i] = 1'b0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        logic ro, re;
        step(1'b0, 2'd0, 24'h0, 4'h0, 1'b1, ro, re);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic ro, re;
        step(1'b1, 2'd1, 24'h5A5A5A, 4'hF, 1'b1, ro, re);
        step(1'b1, 2'd2, 24'hA5A5A5, 4'h0, 1'b1, ro, re);
        checks++;
        if (ifc.DaljaValid !== 4'h0) begin
            errors++; $display("FAIL reset_valid: got %b want 0000", ifc.DaljaValid);
        end
        checks++;
        if (ifc.Zene !== 3'd0) begin
            errors++; $display("FAIL reset_zene: got %0d want 0", ifc.Zene);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (lane_out(i) !== 24'h0) begin
                errors++; $display("FAIL reset_data%0d: got %h want 000000", i, lane_out(i));
            end
        end
    endtask

    task automatic test_single();
        logic ro, re;
        do_reset();
        step(1'b1, 2'd2, 24'hABCDEF, 4'h0, 1'b0, ro, re);
        ifc.HyrjaValid = 1'b0;
        checks++;
        if (ifc.Dalja2 !== 24'hABCDEF) begin
            errors++; $display("FAIL single_data: got %h want abcdef", ifc.Dalja2);
        end
        checks++;
        if (ifc.DaljaValid !== 4'b0100) begin
            errors++; $display("FAIL single_valid: got %b want 0100", ifc.DaljaValid);
        end
        checks++;
        if (ifc.Zene !== 3'd1) begin
            errors++; $display("FAIL single_zene: got %0d want 1", ifc.Zene);
        end
    endtask

    task automatic test_stall();
        logic ro, re;
        do_reset();
        step(1'b1, 2'd1, 24'h111111, 4'h0, 1'b0, ro, re);
        step(1'b1, 2'd1, 24'h222222, 4'h0, 1'b0, ro, re);
        checks++;
        if (ro !== 1'b0) begin
            errors++; $display("FAIL stall_ready: got %b want 0", ro);
        end
        checks++;
        if (ifc.Dalja1 !== 24'h111111) begin
            errors++; $display("FAIL stall_hold: got %h want 111111", ifc.Dalja1);
        end
        step(1'b1, 2'd3, 24'h333333, 4'h0, 1'b0, ro, re);
        checks++;
        if (ro !== 1'b1) begin
            errors++; $display("FAIL other_lane_ready: got %b want 1", ro);
        end
        checks++;
        if (ifc.DaljaValid !== 4'b1010 || ifc.Dalja3 !== 24'h333333) begin
            errors++;
            $display("FAIL other_lane_fill: got valid=%b d3=%h want 1010 333333", ifc.DaljaValid, ifc.Dalja3);
        end
    endtask

    task automatic test_back_to_back();
        logic ro, re;
        do_reset();
        step(1'b1, 2'd0, 24'h000001, 4'h0, 1'b0, ro, re);
        step(1'b1, 2'd0, 24'h000002, 4'b0001, 1'b0, ro, re);
        checks++;
        if (ro !== 1'b1) begin
            errors++; $display("FAIL b2b_ready: got %b want 1", ro);
        end
        checks++;
        if (ifc.Dalja0 !== 24'h000002 || ifc.DaljaValid !== 4'b0001 || ifc.Zene !== 3'd1) begin
            errors++;
            $display("FAIL b2b_state: got d0=%h valid=%b zene=%0d want 000002 0001 1",
                     ifc.Dalja0, ifc.DaljaValid, ifc.Zene);
        end
    endtask

    task automatic test_fill_drain();
        logic ro, re;
        logic [23:0] w;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            w = 24'h11 * 24'(i + 1);
            step(1'b1, 2'(i), w, 4'h0, 1'b0, ro, re);
        end
        checks++;
        if (ifc.Zene !== 3'd4 || ifc.DaljaValid !== 4'hF) begin
            errors++; $display("FAIL fill_full: got zene=%0d valid=%b want 4 1111", ifc.Zene, ifc.DaljaValid);
        end
        checks++;
        if (ifc.Dalja0 !== 24'h11 || ifc.Dalja1 !== 24'h22 || ifc.Dalja2 !== 24'h33 || ifc.Dalja3 !== 24'h44) begin
            errors++;
            $display("FAIL fill_data: got %h %h %h %h want 000011 000022 000033 000044",
                     ifc.Dalja0, ifc.Dalja1, ifc.Dalja2, ifc.Dalja3);
        end
        for (int k = 3; k >= 0; k--) begin
            step(1'b0, 2'd0, 24'h0, 4'(1 << k), 1'b0, ro, re);
            checks++;
            if (ifc.Zene !== 3'(k)) begin
                errors++; $display("FAIL drain_zene%0d: got %0d want %0d", k, ifc.Zene, k);
            end
        end
        checks++;
        if (ifc.Dalja2 !== 24'h33) begin
            errors++; $display("FAIL drain_keeps_data: got %h want 000033", ifc.Dalja2);
        end
    endtask

    task automatic test_reset_priority();
        logic ro, re;
        do_reset();
        step(1'b1, 2'd0, 24'h0A0A0A, 4'h0, 1'b0, ro, re);
        step(1'b1, 2'd2, 24'h0B0B0B, 4'h0, 1'b0, ro, re);
        step(1'b1, 2'd1, 24'hFFFFFF, 4'h0, 1'b1, ro, re);
        rst = 1'b0;
        ifc.HyrjaValid = 1'b0;
        checks++;
        if (ifc.DaljaValid !== 4'h0 || ifc.Zene !== 3'd0) begin
            errors++; $display("FAIL rstprio_state: got valid=%b zene=%0d want 0000 0", ifc.DaljaValid, ifc.Zene);
        end
        checks++;
        if (ifc.Dalja0 !== 24'h0 || ifc.Dalja1 !== 24'h0 || ifc.Dalja2 !== 24'h0 || ifc.Dalja3 !== 24'h0) begin
            errors++;
            $display("FAIL rstprio_data: got %h %h %h %h want all 000000",
                     ifc.Dalja0, ifc.Dalja1, ifc.Dalja2, ifc.Dalja3);
        end
    endtask

    task automatic test_random();
        logic        ro, re, v, hold;
        logic [1:0]  s;
        logic [23:0] d;
        logic [3:0]  dr;
        do_reset();
        model_acc = 0;
        obs_acc   = 0;
        hold = 1'b0;
        v = 1'b0; s = 2'd0; d = 24'h0;
        for (int n = 0; n < 10000; n++) begin
            if (!hold) begin
                v = ($urandom_range(0, 9) < 7);
                s = 2'($urandom);
                d = 24'($urandom);
            end
            dr = 4'($urandom);
            step(v, s, d, dr, 1'b0, ro, re);
            hold = v && !ro;
            checks++;
            if (ro !== re) begin
                errors++; $display("FAIL rnd_ready cyc %0d: got %b want %b", n, ro, re);
            end
            checks++;
            if (ifc.DaljaValid !== mvec()) begin
                errors++; $display("FAIL rnd_valid cyc %0d: got %b want %b", n, ifc.DaljaValid, mvec());
            end
            checks++;
            if (ifc.Zene !== mzene()) begin
                errors++; $display("FAIL rnd_zene cyc %0d: got %0d want %0d", n, ifc.Zene, mzene());
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (lane_out(i) !== mdata[i]) begin
                    errors++; $display("FAIL rnd_data%0d cyc %0d: got %h want %h", i, n, lane_out(i), mdata[i]);
                end
            end
        end
        checks++;
        if (obs_acc !== model_acc) begin
            errors++; $display("FAIL rnd_accept_count: got %0d want %0d", obs_acc, model_acc);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            mvalid[i] = 1'b0;
            mdata[i]  = 24'h0;
        end
        ifc.HyrjaValid = 1'b0;
        ifc.S          = 2'd0;
        ifc.Hyrja      = 24'h0;
        ifc.DaljaReady = 4'h0;
        @(negedge clk);
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_fill_drain();
        test_reset_priority();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
